// File: rtl/gaussian_stream_filter.sv
// Streaming 5x5 smoothing filter (Gaussian 5x5, Gaussian 3x3 or bypass) with valid/ready on both sides.
// Define GAUSS_ROUND_EN for round-to-nearest normalisation; without it results are truncated.
module gaussian_stream_filter #(
   parameter int PIX_W = 5,
   parameter int IMG_W = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         mode,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [5*PIX_W-1:0] pixel_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PIX_W-1:0]   pixel_out,
   output logic               out_last
);

   localparam int SUM_W  = PIX_W + 8;
   localparam int PROD_W = SUM_W + 8;
   localparam int CNT_W  = $clog2(IMG_W);
`ifdef GAUSS_ROUND_EN
   localparam int R0 = 8192;
   localparam int R1 = 8;
`else
   localparam int R0 = 0;
   localparam int R1 = 0;
`endif
   localparam logic [PIX_W-1:0] PIX_MAX = '1;

   // Oldest column is never needed once shifted out, so only the four newest are stored.
   logic [5*PIX_W-1:0] win_q [4];
   logic [CNT_W-1:0]   cnt_q;
   logic [1:0]         mode_q;

   logic               s1_valid;
   logic               s1_last;
   logic [1:0]         s1_mode;
   logic [SUM_W-1:0]   s1_sum;
   logic [PIX_W-1:0]   s1_centre;

   logic               stall;
   logic               accept;
   logic [1:0]         strip_mode;
   logic [SUM_W-1:0]   sum_g5;
   logic [SUM_W-1:0]   sum_g3;
   logic [SUM_W-1:0]   sum_sel;
   logic [PROD_W-1:0]  sum_w;
   logic [PROD_W-1:0]  prod_103;
   logic [PROD_W-1:0]  norm;
   logic [PIX_W-1:0]   result;

   function automatic logic [SUM_W-1:0] px(input logic [5*PIX_W-1:0] c, input int r);
      return SUM_W'(c[r*PIX_W +: PIX_W]);
   endfunction

   // Column kernels 2-4-5-4-2, 4-9-12-9-4 and 5-12-15-12-5, folded on the row symmetry.
   function automatic logic [SUM_W-1:0] col_a(input logic [5*PIX_W-1:0] c);
      logic [SUM_W-1:0] o, i, m;
      o = px(c, 0) + px(c, 4);
      i = px(c, 1) + px(c, 3);
      m = px(c, 2);
      return (o << 1) + (i << 2) + (m << 2) + m;
   endfunction

   function automatic logic [SUM_W-1:0] col_b(input logic [5*PIX_W-1:0] c);
      logic [SUM_W-1:0] o, i, m;
      o = px(c, 0) + px(c, 4);
      i = px(c, 1) + px(c, 3);
      m = px(c, 2);
      return (o << 2) + (i << 3) + i + (m << 3) + (m << 2);
   endfunction

   function automatic logic [SUM_W-1:0] col_c(input logic [5*PIX_W-1:0] c);
      logic [SUM_W-1:0] o, i, m;
      o = px(c, 0) + px(c, 4);
      i = px(c, 1) + px(c, 3);
      m = px(c, 2);
      return (o << 2) + o + (i << 3) + (i << 2) + (m << 3) + (m << 2) + (m << 1) + m;
   endfunction

   function automatic logic [SUM_W-1:0] col_t(input logic [5*PIX_W-1:0] c);
      return px(c, 1) + (px(c, 2) << 1) + px(c, 3);
   endfunction

   assign stall      = out_valid & ~out_ready;
   assign in_ready   = ~stall;
   assign accept     = in_valid & in_ready;
   assign strip_mode = (cnt_q == '0) ? mode : mode_q;

   // Sums are taken over the window as it stands after this accept's shift.
   always_comb begin
      sum_g5  = col_a(win_q[0]) + col_b(win_q[1]) + col_c(win_q[2]) + col_b(win_q[3]) + col_a(pixel_in);
      sum_g3  = col_t(win_q[1]) + (col_t(win_q[2]) << 1) + col_t(win_q[3]);
      sum_sel = (strip_mode == 2'd0) ? sum_g5 : sum_g3;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) win_q[i] <= '0;
         cnt_q  <= '0;
         mode_q <= 2'd0;
      end else if (accept) begin
         win_q[0] <= win_q[1];
         win_q[1] <= win_q[2];
         win_q[2] <= win_q[3];
         win_q[3] <= pixel_in;
         cnt_q    <= (cnt_q == CNT_W'(IMG_W - 1)) ? '0 : cnt_q + CNT_W'(1);
         if (cnt_q == '0) mode_q <= mode;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_mode   <= 2'd0;
         s1_sum    <= '0;
         s1_centre <= '0;
      end else if (!stall) begin
         s1_valid <= accept && (cnt_q >= CNT_W'(4));
         s1_last  <= accept && (cnt_q == CNT_W'(IMG_W - 1));
         if (accept) begin
            s1_mode   <= strip_mode;
            s1_sum    <= sum_sel;
            s1_centre <= win_q[2][2*PIX_W +: PIX_W];
         end
      end
   end

   // 103/16384 approximates 1/159; x103 is built as 64+32+4+2+1.
   always_comb begin
      sum_w    = PROD_W'(s1_sum);
      prod_103 = (sum_w << 6) + (sum_w << 5) + (sum_w << 2) + (sum_w << 1) + sum_w;
      case (s1_mode)
         2'd0:    norm = (prod_103 + PROD_W'(R0)) >> 14;
         2'd1:    norm = (sum_w + PROD_W'(R1)) >> 4;
         default: norm = PROD_W'(s1_centre);
      endcase
      result = (norm > PROD_W'(PIX_MAX)) ? PIX_MAX : norm[PIX_W-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         pixel_out <= '0;
         out_last  <= 1'b0;
      end else if (!stall) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            pixel_out <= result;
            out_last  <= s1_last;
         end
      end
   end

endmodule

// File: tb/tb_gaussian_stream_filter.sv
// Self-checking bench for gaussian_stream_filter: directed cases plus a randomized run scored
// against a strip-level behavioural model.
module tb_gaussian_stream_filter;

   localparam int PIX_W = 5;
   localparam int IMG_W = 8;
   localparam int PMAX  = 31;
`ifdef GAUSS_ROUND_EN
   localparam int R0 = 8192;
   localparam int R1 = 8;
   localparam int G_ALL31 = 31;
   localparam int G_SPOT  = 2;
`else
   localparam int R0 = 0;
   localparam int R1 = 0;
   localparam int G_ALL31 = 30;
   localparam int G_SPOT  = 1;
`endif

   logic               clk;
   logic               reset;
   logic [1:0]         mode;
   logic               in_valid;
   logic               in_ready;
   logic [5*PIX_W-1:0] pixel_in;
   logic               out_valid;
   logic               out_ready;
   logic [PIX_W-1:0]   pixel_out;
   logic               out_last;

   int n_checks = 0;
   int n_fail   = 0;
   bit rand_ready = 0;

   int k5 [5][5] = '{'{2, 4, 5, 4, 2}, '{4, 9, 12, 9, 4}, '{5, 12, 15, 12, 5},
                     '{4, 9, 12, 9, 4}, '{2, 4, 5, 4, 2}};
   int k3 [5][5] = '{'{0, 0, 0, 0, 0}, '{0, 1, 2, 1, 0}, '{0, 2, 4, 2, 0},
                     '{0, 1, 2, 1, 0}, '{0, 0, 0, 0, 0}};

   logic [5*PIX_W-1:0] strip_cols [$];
   int m_cnt  = 0;
   int m_mode = 0;
   int exp_pix [$];
   bit exp_last [$];
   int got_pix [$];
   bit got_last [$];
   bit prev_stall = 0;
   logic [PIX_W-1:0] prev_pix;
   logic prev_last;

   gaussian_stream_filter #(.PIX_W(PIX_W), .IMG_W(IMG_W)) dut (
      .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
      .pixel_in(pixel_in), .out_valid(out_valid), .out_ready(out_ready),
      .pixel_out(pixel_out), .out_last(out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Plain weighted-sum reference straight from the kernel tables.
   function automatic int model_pixel(input int md, input logic [5*PIX_W-1:0] w [5]);
      int s, res, p;
      s = 0;
      for (int c = 0; c < 5; c++)
         for (int r = 0; r < 5; r++) begin
            p = int'(w[c][r*PIX_W +: PIX_W]);
            s += ((md == 0) ? k5[c][r] : k3[c][r]) * p;
         end
      if (md == 0)      res = (s * 103 + R0) / 16384;
      else if (md == 1) res = (s + R1) / 16;
      else              res = int'(w[2][2*PIX_W +: PIX_W]);
      if (res > PMAX) res = PMAX;
      return res;
   endfunction

   always @(negedge clk) begin
      logic [5*PIX_W-1:0] w [5];
      if (!reset) begin
         strip_cols.delete();
         exp_pix.delete();
         exp_last.delete();
         got_pix.delete();
         got_last.delete();
         m_cnt = 0;
         prev_stall = 0;
      end else begin
         checkOutput("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
         if (prev_stall) begin
            checkOutput("hold_valid", int'(out_valid), 1);
            checkOutput("hold_pix", int'(pixel_out), int'(prev_pix));
            checkOutput("hold_last", int'(out_last), int'(prev_last));
         end
         if (out_valid && out_ready) begin
            got_pix.push_back(int'(pixel_out));
            got_last.push_back(out_last);
            if (exp_pix.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL unexpected_out: got pixel %0d, expected no result", pixel_out);
            end else begin
               checkOutput("result_pix", int'(pixel_out), exp_pix.pop_front());
               checkOutput("result_last", int'(out_last), int'(exp_last.pop_front()));
            end
         end
         if (in_valid && in_ready) begin
            if (m_cnt == 0) begin
               strip_cols.delete();
               m_mode = int'(mode);
            end
            strip_cols.push_back(pixel_in);
            if (m_cnt >= 4) begin
               for (int c = 0; c < 5; c++) w[c] = strip_cols[m_cnt - 4 + c];
               exp_pix.push_back(model_pixel(m_mode, w));
               exp_last.push_back(m_cnt == IMG_W - 1);
            end
            m_cnt = (m_cnt == IMG_W - 1) ? 0 : m_cnt + 1;
         end
         prev_stall = out_valid && !out_ready;
         prev_pix   = pixel_out;
         prev_last  = out_last;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Offers one column and holds it until the filter takes it.
   task automatic applyStimulus(input logic [5*PIX_W-1:0] col);
      bit accepted;
      accepted = 0;
      in_valid = 1'b1;
      pixel_in = col;
      for (int t = 0; t < 200 && !accepted; t++) begin
         @(negedge clk);
         accepted = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      checkOutput("accept_timeout", int'(accepted), 1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkLog(input string name, input int idx, input int exp_p);
      if (idx >= got_pix.size()) checkOutput(name, -1, exp_p);
      else                       checkOutput(name, got_pix[idx], exp_p);
   endtask

   function automatic logic [5*PIX_W-1:0] uni(input int v);
      return {5{PIX_W'(v)}};
   endfunction

   task automatic spotStrip(input int md, input int md_after);
      logic [5*PIX_W-1:0] spot;
      spot = (5*PIX_W)'(16) << (2*PIX_W);
      mode = 2'(md);
      for (int c = 0; c < IMG_W; c++) begin
         applyStimulus(c == 2 ? spot : '0);
         mode = 2'(md_after);
      end
      idle(3);
   endtask

   initial begin
      reset = 1'b1;
      mode = 2'd0;
      in_valid = 1'b0;
      pixel_in = '0;
      out_ready = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", int'(out_valid), 0);
      checkOutput("reset_pixel_out", int'(pixel_out), 0);
      checkOutput("reset_out_last", int'(out_last), 0);
      checkOutput("reset_in_ready", int'(in_ready), 1);
      reset = 1'b1;
      idle(1);

      $display("[TB] mode 0, flat 31, latency");
      mode = 2'd0;
      for (int c = 0; c < 5; c++) applyStimulus(uni(31));
      checkOutput("lat_not_yet", int'(out_valid), 0);
      applyStimulus(uni(31));
      checkOutput("lat_valid", int'(out_valid), 1);
      checkOutput("lat_pix", int'(pixel_out), G_ALL31);
      applyStimulus(uni(31));
      applyStimulus(uni(31));
      idle(3);
      checkOutput("flat_count", got_pix.size(), 4);
      for (int i = 0; i < 4; i++) checkLog("flat_pix", i, G_ALL31);
      if (got_last.size() == 4) begin
         checkOutput("flat_last0", int'(got_last[0]), 0);
         checkOutput("flat_last3", int'(got_last[3]), 1);
      end

      $display("[TB] centred spot in modes 0, 1, 2");
      got_pix.delete(); got_last.delete();
      spotStrip(0, 0);
      checkLog("spot_g5", 0, G_SPOT);
      got_pix.delete(); got_last.delete();
      spotStrip(1, 1);
      checkLog("spot_g3", 0, 4);
      got_pix.delete(); got_last.delete();
      spotStrip(2, 2);
      checkLog("spot_bypass", 0, 16);

      $display("[TB] mode held across mid-strip change");
      got_pix.delete(); got_last.delete();
      mode = 2'd1;
      for (int c = 0; c < IMG_W; c++) begin
         applyStimulus(uni(31));
         if (c == 2) mode = 2'd0;
      end
      idle(3);
      for (int i = 0; i < 4; i++) checkLog("g3_flat31", i, 31);
      got_pix.delete(); got_last.delete();
      spotStrip(1, 2);
      checkLog("mode_held", 0, 4);

      $display("[TB] output backpressure");
      got_pix.delete(); got_last.delete();
      mode = 2'd0;
      fork
         begin
            logic [5*PIX_W-1:0] col;
            for (int c = 0; c < IMG_W; c++) begin
               for (int r = 0; r < 5; r++) col[r*PIX_W +: PIX_W] = PIX_W'((c * 3 + r * 5) % 32);
               applyStimulus(col);
            end
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            out_ready = 1'b0;
            #1;
            checkOutput("stall_out_valid", int'(out_valid), 1);
            checkOutput("stall_in_ready", int'(in_ready), 0);
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      idle(4);
      checkOutput("stall_count", got_pix.size(), 4);
      if (got_last.size() == 4) checkOutput("stall_last", int'(got_last[3]), 1);

      $display("[TB] back-to-back strips");
      got_pix.delete(); got_last.delete();
      mode = 2'd1;
      for (int c = 0; c < 2 * IMG_W; c++) applyStimulus(uni(c < IMG_W ? 10 : 20));
      idle(3);
      for (int i = 0; i < 8; i++) checkLog("strip_pix", i, (i < 4) ? 10 : 20);
      if (got_last.size() == 8) begin
         checkOutput("strip_last_a", int'(got_last[3]), 1);
         checkOutput("strip_last_b", int'(got_last[7]), 1);
      end

      $display("[TB] reset mid-strip");
      mode = 2'd2;
      for (int c = 0; c < 6; c++) applyStimulus(uni(c + 1));
      checkOutput("pre_reset_valid", int'(out_valid), 1);
      reset = 1'b0;
      #1;
      checkOutput("reset_kills_valid", int'(out_valid), 0);
      checkOutput("reset_kills_pix", int'(pixel_out), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(1);
      for (int c = 0; c < 4; c++) applyStimulus(uni(c + 7));
      idle(3);
      checkOutput("no_early_result", got_pix.size(), 0);
      for (int c = 4; c < IMG_W; c++) applyStimulus(uni(c + 7));
      idle(3);
      checkOutput("post_reset_count", got_pix.size(), 4);
      checkLog("post_reset_first", 0, 9);

      $display("[TB] randomized run");
      rand_ready = 1;
      for (int s = 0; s < 30; s++)
         for (int c = 0; c < IMG_W; c++) begin
            mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle(1);
            applyStimulus((5*PIX_W)'($urandom));
         end
      rand_ready = 0;
      out_ready = 1'b1;
      idle(6);
      checkOutput("drained", exp_pix.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
